pipe_wb_unit: RTL and testbench
===============================

Name: pipe_wb_unit

Overview:
Parametrised writeback stage for the dynamic pipeline CPU. It contains the MEM/WB pipeline register, with stall/flush control and a valid bit. It also holds the architectural HI/LO registers, performs sub-word load extraction, selects the register-file writeback source, and keeps a retired-instruction counter. It sits between the MEM stage and the register file / HI-LO write ports, and it supplies forwarding data back to ID/EX.

Parameters:
DATA_W, 32, datapath width (must be >= 16, multiple of 8)
RN_W, 5, register-number width
CNT_W, 32, retire-counter width (<= DATA_W; zero-extended when read)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous reset, active-low
m_valid  in  1  MEM stage holds a real instruction
wb_stall  in  1  hold stage register contents
wb_flush  in  1  insert bubble into stage
m_alu  in  DATA_W  ALU result / memory address
m_a  in  DATA_W  rs operand (MTHI/MTLO source)
m_dm  in  DATA_W  raw data-memory word
m_muler_hi  in  DATA_W  multiplier high word
m_muler_lo  in  DATA_W  multiplier low word
m_q  in  DATA_W  divider quotient
m_r  in  DATA_W  divider remainder
m_cp0  in  DATA_W  CP0 read data
m_pc4  in  DATA_W  PC+4 (link address)
m_rfsource  in  3  RF writeback select
m_hisource  in  2  HI source select
m_losource  in  2  LO source select
m_ld_size  in  2  00 word, 01 half, 10 byte, 11 word
m_ld_signed  in  1  sign-extend sub-word load
m_rn  in  RN_W  destination register
m_w_rf, m_w_hi, m_w_lo  in  1 each  write enables
Wdata_rf  out  DATA_W  RF write data
Wrn  out  RN_W  RF write address
Ww_rf  out  1  RF write strobe
Wdata_hi, Wdata_lo  out  DATA_W  values written to HI/LO this cycle
Ww_hi, Ww_lo  out  1  HI/LO write strobes
hi_q, lo_q  out  DATA_W  current architectural HI/LO
retire_cnt  out  CNT_W  instructions retired

Behaviour:
- Stage register update priority on each rising edge:
  - !resetn: clear valid, all enables, all data fields.
  - Otherwise wb_flush: valid <= 0, enables <= 0, data don't-care.
  - Otherwise wb_stall: hold all fields.
  - Otherwise: capture all m_* fields, with valid <= m_valid.
- Latency: one cycle from capture to W* outputs. All W* outputs are combinational from the stage register and hi_q/lo_q.
- Strobes:
  - Ww_rf = valid & w_rf & (Wrn != 0) & !wb_stall.
  - Ww_hi = valid & w_hi & !wb_stall.
  - Ww_lo = valid & w_lo & !wb_stall.
  - A stalled instruction commits exactly once, on the cycle it leaves.
- Load extraction uses offset = alu[1:0], little-endian:
  - Byte: dm[8*offset+7 : 8*offset].
  - Half: offset[1] selects the upper/lower 16 bits; offset[0] is ignored.
  - Sign or zero extension to DATA_W per ld_signed.
- rfsource encoding: 0 alu, 1 extracted load, 2 muler_lo, 3 hi_q, 4 lo_q, 5 cp0, 6 pc4, 7 retire_cnt (zero-extended).
- hisource: 0 a, 1 muler_hi, 2 r, 3 hi_q (hold). losource: 0 a, 1 muler_lo, 2 q, 3 lo_q.
- HI/LO registers:
  - hi_q <= Wdata_hi when Ww_hi; lo_q <= Wdata_lo when Ww_lo; both reset to 0.
  - An MFHI/MFLO in WB reads the pre-update value.
  - Simultaneous HI and LO writes (MULT/DIV) are both committed in the same cycle.
- retire_cnt:
  - Increments by 1 when valid & !wb_stall; wraps at 2^CNT_W-1 -> 0; resets to 0.
  - rfsource 7 returns the pre-increment value.
- Reset asserted mid-stall drops the held instruction without committing it.
- Flush while stalled: flush wins, and the instruction is not committed.

Decomposition:
- pipe_wb_pkg:
  - RFSRC_* constants (0..7).
  - HISRC_*/LOSRC_* constants.
  - LD_WORD/LD_HALF/LD_BYTE.
  - Typedef for the stage-register control bundle.
- Sub-module wb_load_extract: combinational byte/half select and extension, parametrised on DATA_W.

Test Plan:
- Reset then idle: all W* outputs 0, hi_q = lo_q = 0, retire_cnt = 0; after 3 bubbles (m_valid = 0), retire_cnt is still 0.
- Load byte, signed: alu = 0x...03, dm = 0x80FF_1234, rfsource = 1, rn = 8 -> Wdata_rf = 0xFFFF_FF80, Ww_rf = 1. Same stimulus unsigned -> 0x0000_0080. Half, offset 2, signed -> 0xFFFF_80FF.
- Write to $0: rn = 0, w_rf = 1, alu = 0x1234 -> Ww_rf = 0; retire_cnt still increments.
- MULT then MFLO:
  - MULT with muler_hi = 0xDEAD, muler_lo = 0xBEEF, hisource = 1, losource = 1, both w = 1 -> next cycle hi_q = 0xDEAD, lo_q = 0xBEEF.
  - Following MFLO (rfsource = 4) -> Wdata_rf = 0xBEEF.
- Stall and flush:
  - Instruction held 3 cycles under wb_stall -> Ww_rf low during the stall, high exactly one cycle on release; retire_cnt +1 total.
  - wb_flush asserted during the stall -> zero commits.
- Counter wrap with CNT_W = 4: retire 16 instructions -> retire_cnt returns to 0. An rfsource 7 read at count 15 returns 15.

Source files
------------

// File: rtl/pipe_wb_pkg.sv
// Shared encodings and the control bundle carried by the MEM/WB stage register.
// Source selects are enums so waveforms show mnemonic names rather than raw codes.
package pipe_wb_pkg;

  typedef enum logic [2:0] {
    RFSRC_ALU    = 3'd0,
    RFSRC_LOAD   = 3'd1,
    RFSRC_MULLO  = 3'd2,
    RFSRC_HI     = 3'd3,
    RFSRC_LO     = 3'd4,
    RFSRC_CP0    = 3'd5,
    RFSRC_PC4    = 3'd6,
    RFSRC_RETIRE = 3'd7
  } rfsrc_e;

  typedef enum logic [1:0] {
    HISRC_A     = 2'd0,
    HISRC_MULHI = 2'd1,
    HISRC_REM   = 2'd2,
    HISRC_HOLD  = 2'd3
  } hisrc_e;

  typedef enum logic [1:0] {
    LOSRC_A     = 2'd0,
    LOSRC_MULLO = 2'd1,
    LOSRC_QUO   = 2'd2,
    LOSRC_HOLD  = 2'd3
  } losrc_e;

  localparam logic [1:0] LD_WORD     = 2'b00;
  localparam logic [1:0] LD_HALF     = 2'b01;
  localparam logic [1:0] LD_BYTE     = 2'b10;
  localparam logic [1:0] LD_WORD_ALT = 2'b11;

  typedef struct packed {
    logic     w_rf;
    logic     w_hi;
    logic     w_lo;
    rfsrc_e   rfsource;
    hisrc_e   hisource;
    losrc_e   losource;
    logic [1:0] ld_size;
    logic     ld_signed;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_IDLE = '{
    w_rf: 1'b0, w_hi: 1'b0, w_lo: 1'b0,
    rfsource: RFSRC_ALU, hisource: HISRC_A, losource: LOSRC_A,
    ld_size: LD_WORD, ld_signed: 1'b0
  };

  // A killed bundle keeps its selects but can never write anything.
  function automatic wb_ctrl_t ctrl_kill(input wb_ctrl_t c);
    wb_ctrl_t k;
    k      = c;
    k.w_rf = 1'b0;
    k.w_hi = 1'b0;
    k.w_lo = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/wb_load_extract.sv
// Sub-word load extraction: little-endian byte/half select from the raw memory word.
// Purely combinational; no handshake.
module wb_load_extract
  import pipe_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] dm_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = dm_i[{offset_i, 3'b000} +: 8];
  // Halfword loads are assumed aligned, so the low offset bit is ignored.
  assign half_v = dm_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = dm_i;
    case (ld_size_i)
      LD_BYTE: data_o = ld_signed_i ? DATA_W'($signed(byte_v)) : DATA_W'(byte_v);
      LD_HALF: data_o = ld_signed_i ? DATA_W'($signed(half_v)) : DATA_W'(half_v);
      default: data_o = dm_i;
    endcase
  end

endmodule

// File: rtl/pipe_wb_unit.sv
// MEM/WB stage register, HI/LO architectural state, writeback select and retire counter.
// W* outputs are combinational from the stage register; wb_stall holds and suppresses commit.
module pipe_wb_unit
  import pipe_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_a,
  input  logic [DATA_W-1:0] m_dm,
  input  logic [DATA_W-1:0] m_muler_hi,
  input  logic [DATA_W-1:0] m_muler_lo,
  input  logic [DATA_W-1:0] m_q,
  input  logic [DATA_W-1:0] m_r,
  input  logic [DATA_W-1:0] m_cp0,
  input  logic [DATA_W-1:0] m_pc4,
  input  logic [2:0]        m_rfsource,
  input  logic [1:0]        m_hisource,
  input  logic [1:0]        m_losource,
  input  logic [1:0]        m_ld_size,
  input  logic              m_ld_signed,
  input  logic [RN_W-1:0]   m_rn,
  input  logic              m_w_rf,
  input  logic              m_w_hi,
  input  logic              m_w_lo,
  output logic [DATA_W-1:0] Wdata_rf,
  output logic [RN_W-1:0]   Wrn,
  output logic              Ww_rf,
  output logic [DATA_W-1:0] Wdata_hi,
  output logic [DATA_W-1:0] Wdata_lo,
  output logic              Ww_hi,
  output logic              Ww_lo,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] cp0;
    logic [DATA_W-1:0] pc4;
  } wb_data_t;

  logic              valid_q, valid_d;
  wb_ctrl_t          ctrl_q, ctrl_d;
  logic [RN_W-1:0]   rn_q, rn_d;
  wb_data_t          data_q, data_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] ld_data;
  logic              commit;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rn_d    = rn_q;
    data_d  = data_q;
    if (wb_flush) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_kill(ctrl_q);
    end else if (!wb_stall) begin
      valid_d = m_valid;
      ctrl_d  = '{
        w_rf: m_w_rf, w_hi: m_w_hi, w_lo: m_w_lo,
        rfsource: rfsrc_e'(m_rfsource),
        hisource: hisrc_e'(m_hisource),
        losource: losrc_e'(m_losource),
        ld_size: m_ld_size, ld_signed: m_ld_signed
      };
      rn_d    = m_rn;
      data_d  = '{
        alu: m_alu, a: m_a, dm: m_dm, mul_hi: m_muler_hi, mul_lo: m_muler_lo,
        quo: m_q, rem: m_r, cp0: m_cp0, pc4: m_pc4
      };
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ctrl_q  <= WB_CTRL_IDLE;
      rn_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rn_q    <= rn_d;
      data_q  <= data_d;
    end
  end

  wb_load_extract #(
    .DATA_W(DATA_W)
  ) u_load_extract (
    .dm_i       (data_q.dm),
    .offset_i   (data_q.alu[1:0]),
    .ld_size_i  (ctrl_q.ld_size),
    .ld_signed_i(ctrl_q.ld_signed),
    .data_o     (ld_data)
  );

  // Gating with resetn keeps a held instruction from committing on the reset cycle.
  assign commit = resetn & valid_q & ~wb_stall;
  assign Ww_rf  = commit & ctrl_q.w_rf & (rn_q != '0);
  assign Ww_hi  = commit & ctrl_q.w_hi;
  assign Ww_lo  = commit & ctrl_q.w_lo;
  assign Wrn    = rn_q;

  always_comb begin
    Wdata_rf = data_q.alu;
    case (ctrl_q.rfsource)
      RFSRC_ALU:    Wdata_rf = data_q.alu;
      RFSRC_LOAD:   Wdata_rf = ld_data;
      RFSRC_MULLO:  Wdata_rf = data_q.mul_lo;
      RFSRC_HI:     Wdata_rf = hi_q;
      RFSRC_LO:     Wdata_rf = lo_q;
      RFSRC_CP0:    Wdata_rf = data_q.cp0;
      RFSRC_PC4:    Wdata_rf = data_q.pc4;
      RFSRC_RETIRE: Wdata_rf = DATA_W'(cnt_q);
      default:      Wdata_rf = data_q.alu;
    endcase
  end

  always_comb begin
    Wdata_hi = hi_q;
    case (ctrl_q.hisource)
      HISRC_A:     Wdata_hi = data_q.a;
      HISRC_MULHI: Wdata_hi = data_q.mul_hi;
      HISRC_REM:   Wdata_hi = data_q.rem;
      HISRC_HOLD:  Wdata_hi = hi_q;
      default:     Wdata_hi = hi_q;
    endcase
  end

  always_comb begin
    Wdata_lo = lo_q;
    case (ctrl_q.losource)
      LOSRC_A:     Wdata_lo = data_q.a;
      LOSRC_MULLO: Wdata_lo = data_q.mul_lo;
      LOSRC_QUO:   Wdata_lo = data_q.quo;
      LOSRC_HOLD:  Wdata_lo = lo_q;
      default:     Wdata_lo = lo_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (Ww_hi) hi_q <= Wdata_hi;
      if (Ww_lo) lo_q <= Wdata_lo;
      if (commit) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_unit.sv
// Randomised and directed bench for pipe_wb_unit against a transaction-level model.
module tb_pipe_wb_unit;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu, a, dm, mhi, mlo, q, r, cp0, pc4;
    logic [2:0]  rfs;
    logic [1:0]  hs, ls, sz;
    logic        sg;
    logic [4:0]  rn;
    logic        wrf, whi, wlo;
  } instr_t;

  logic clk = 1'b0;
  logic resetn, wb_stall, wb_flush;
  instr_t in;

  logic [31:0] Wdata_rf, Wdata_hi, Wdata_lo, hi_q, lo_q;
  logic [4:0]  Wrn;
  logic        Ww_rf, Ww_hi, Ww_lo;
  logic [3:0]  retire_cnt;

  always #5 clk = ~clk;

  pipe_wb_unit #(.DATA_W(32), .RN_W(5), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .m_valid(in.valid), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .m_alu(in.alu), .m_a(in.a), .m_dm(in.dm), .m_muler_hi(in.mhi), .m_muler_lo(in.mlo),
    .m_q(in.q), .m_r(in.r), .m_cp0(in.cp0), .m_pc4(in.pc4),
    .m_rfsource(in.rfs), .m_hisource(in.hs), .m_losource(in.ls),
    .m_ld_size(in.sz), .m_ld_signed(in.sg), .m_rn(in.rn),
    .m_w_rf(in.wrf), .m_w_hi(in.whi), .m_w_lo(in.wlo),
    .Wdata_rf(Wdata_rf), .Wrn(Wrn), .Ww_rf(Ww_rf),
    .Wdata_hi(Wdata_hi), .Wdata_lo(Wdata_lo), .Ww_hi(Ww_hi), .Ww_lo(Ww_lo),
    .hi_q(hi_q), .lo_q(lo_q), .retire_cnt(retire_cnt)
  );

  // Model state: the instruction sitting in WB plus architectural HI/LO and count.
  instr_t      st;
  logic [31:0] m_hi, m_lo;
  int          m_cnt;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] dm, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = dm[8*off +: 8];
    h = off[1] ? dm[31:16] : dm[15:0];
    if (sz == 2'b10) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return dm;
  endfunction

  // Check the current cycle against the model, advance the model, move to next negedge.
  task automatic cyc();
    logic        commit, e_wrf, e_whi, e_wlo;
    logic [31:0] e_rf, e_hi, e_lo;
    #1;
    commit = resetn && st.valid && !wb_stall;
    e_wrf  = commit && st.wrf && (st.rn != 0);
    e_whi  = commit && st.whi;
    e_wlo  = commit && st.wlo;
    case (st.hs)
      2'd0: e_hi = st.a;   2'd1: e_hi = st.mhi;
      2'd2: e_hi = st.r;   default: e_hi = m_hi;
    endcase
    case (st.ls)
      2'd0: e_lo = st.a;   2'd1: e_lo = st.mlo;
      2'd2: e_lo = st.q;   default: e_lo = m_lo;
    endcase
    case (st.rfs)
      3'd0: e_rf = st.alu;
      3'd1: e_rf = exp_load(st.dm, st.alu[1:0], st.sz, st.sg);
      3'd2: e_rf = st.mlo;
      3'd3: e_rf = m_hi;
      3'd4: e_rf = m_lo;
      3'd5: e_rf = st.cp0;
      3'd6: e_rf = st.pc4;
      default: e_rf = 32'(m_cnt);
    endcase
    chk("Ww_rf", Ww_rf, e_wrf);
    chk("Ww_hi", Ww_hi, e_whi);
    chk("Ww_lo", Ww_lo, e_wlo);
    chk("hi_q", hi_q, m_hi);
    chk("lo_q", lo_q, m_lo);
    chk("retire_cnt", retire_cnt, m_cnt);
    if (e_wrf) begin
      chk("Wdata_rf", Wdata_rf, e_rf);
      chk("Wrn", Wrn, st.rn);
    end
    if (e_whi) chk("Wdata_hi", Wdata_hi, e_hi);
    if (e_wlo) chk("Wdata_lo", Wdata_lo, e_lo);

    if (!resetn) begin
      st = '0; m_hi = 0; m_lo = 0; m_cnt = 0;
    end else begin
      if (e_whi) m_hi = e_hi;
      if (e_wlo) m_lo = e_lo;
      if (commit) m_cnt = (m_cnt + 1) % 16;
      if (wb_flush) begin
        st.valid = 1'b0; st.wrf = 1'b0; st.whi = 1'b0; st.wlo = 1'b0;
      end else if (!wb_stall) begin
        st = in;
      end
    end
    @(negedge clk);
  endtask

  function automatic instr_t mk(input logic [2:0] rfs, input logic [4:0] rn, input logic wrf);
    instr_t x;
    x = '0;
    x.valid = 1'b1; x.rfs = rfs; x.rn = rn; x.wrf = wrf;
    return x;
  endfunction

  // Present x for one cycle, then leave it in WB with a bubble behind it.
  task automatic issue(input instr_t x);
    in = x;
    cyc();
    in = '0;
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t x;
    x.valid = ($urandom_range(0, 4) != 0);
    x.alu = $urandom; x.a = $urandom; x.dm = $urandom;
    x.mhi = $urandom; x.mlo = $urandom; x.q = $urandom; x.r = $urandom;
    x.cp0 = $urandom; x.pc4 = $urandom;
    x.rfs = 3'($urandom); x.hs = 2'($urandom); x.ls = 2'($urandom);
    x.sz = 2'($urandom); x.sg = 1'($urandom);
    x.rn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    x.wrf = 1'($urandom); x.whi = 1'($urandom); x.wlo = 1'($urandom);
    return x;
  endfunction

  initial begin
    instr_t x;
    resetn = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0; in = '0;
    st = '0; m_hi = 0; m_lo = 0; m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    cyc();
    resetn = 1'b1;
    #1;
    chk("rst_Ww_rf", Ww_rf, 0);     chk("rst_Ww_hi", Ww_hi, 0);
    chk("rst_Ww_lo", Ww_lo, 0);     chk("rst_Wdata_rf", Wdata_rf, 0);
    chk("rst_Wdata_hi", Wdata_hi, 0); chk("rst_Wdata_lo", Wdata_lo, 0);
    chk("rst_Wrn", Wrn, 0);         chk("rst_hi", hi_q, 0);
    chk("rst_lo", lo_q, 0);         chk("rst_cnt", retire_cnt, 0);
    repeat (3) cyc();
    #1 chk("bubbles_cnt", retire_cnt, 0);

    x = mk(3'd1, 5'd8, 1'b1); x.alu = 32'h3; x.dm = 32'h80FF_1234; x.sz = 2'b10; x.sg = 1'b1;
    issue(x);
    chk("lb_signed", Wdata_rf, 32'hFFFF_FF80); chk("lb_strobe", Ww_rf, 1);
    cyc();
    x.sg = 1'b0;
    issue(x);
    chk("lbu", Wdata_rf, 32'h0000_0080);
    cyc();
    x.alu = 32'h2; x.sz = 2'b01; x.sg = 1'b1;
    issue(x);
    chk("lh_off2", Wdata_rf, 32'hFFFF_80FF);
    cyc();

    x = mk(3'd0, 5'd0, 1'b1); x.alu = 32'h1234;
    issue(x);
    chk("r0_strobe", Ww_rf, 0); chk("r0_cnt_pre", retire_cnt, 3);
    cyc();
    #1 chk("r0_cnt_post", retire_cnt, 4);

    x = mk(3'd0, 5'd0, 1'b0); x.mhi = 32'hDEAD; x.mlo = 32'hBEEF;
    x.hs = 2'd1; x.ls = 2'd1; x.whi = 1'b1; x.wlo = 1'b1;
    issue(x);
    chk("mult_whi", Ww_hi, 1); chk("mult_wlo", Ww_lo, 1);
    cyc();
    issue(mk(3'd4, 5'd2, 1'b1));
    chk("mult_hi", hi_q, 32'hDEAD); chk("mult_lo", lo_q, 32'hBEEF);
    chk("mflo", Wdata_rf, 32'hBEEF);
    cyc();

    x = mk(3'd0, 5'd3, 1'b1); x.alu = 32'h55;
    in = x; cyc(); in = '0;
    wb_stall = 1'b1;
    repeat (3) begin
      #1 chk("stall_hold", Ww_rf, 0);
      cyc();
    end
    wb_stall = 1'b0;
    #1 chk("stall_release", Ww_rf, 1); chk("stall_cnt_pre", retire_cnt, 6);
    cyc();
    #1 chk("stall_once", Ww_rf, 0); chk("stall_cnt_post", retire_cnt, 7);

    in = mk(3'd0, 5'd4, 1'b1); cyc(); in = '0;
    wb_stall = 1'b1; cyc();
    wb_flush = 1'b1;
    #1 chk("flush_stall", Ww_rf, 0);
    cyc();
    wb_stall = 1'b0; wb_flush = 1'b0;
    #1 chk("flush_nocommit", Ww_rf, 0); chk("flush_cnt", retire_cnt, 7);
    cyc();

    repeat (8) begin
      issue(mk(3'd0, 5'd5, 1'b1));
      cyc();
    end
    issue(mk(3'd7, 5'd9, 1'b1));
    chk("cnt_read15", Wdata_rf, 15); chk("cnt_at15", retire_cnt, 15);
    cyc();
    #1 chk("cnt_wrap", retire_cnt, 0);

    x = mk(3'd0, 5'd6, 1'b1); x.whi = 1'b1; x.a = 32'h1111;
    in = x; cyc(); in = '0;
    wb_stall = 1'b1; cyc();
    resetn = 1'b0;
    #1 chk("rst_stall_whi", Ww_hi, 0);
    cyc();
    resetn = 1'b1; wb_stall = 1'b0;
    #1 chk("rst_stall_hi", hi_q, 0); chk("rst_stall_wrf", Ww_rf, 0);
    cyc();

    for (int i = 0; i < 1500; i++) begin
      in       = rand_instr();
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_flush = ($urandom_range(0, 9) == 0);
      resetn   = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
